// File: rtl/id_exe_pipe_reg.sv
// ----------------------------------------------------------------------------
// id_exe_pipe_reg
//
// ID -> EXE pipeline register of the ARM forwarding pipeline. Each cycle it
// captures the decoded instruction and its operands from ID and presents them
// to EXE. A hazard stall turns the slot into a bubble; an EXE branch flush
// squashes the slot entirely. Saturating counters record bubbles, flushes and
// issued instructions for pipeline-efficiency measurement.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 branch taken in EXE: clear the whole slot
//   hazard                stall from hazard unit: insert a bubble
//   perf_clr              synchronous clear of the three counters
//   *_in                  decoded instruction fields from ID
//   <name> (no _in)       registered copies presented to EXE
//   exe_valid             slot holds a real instruction
//   bubble_cnt, flush_cnt, issue_cnt   saturating performance counters
// ----------------------------------------------------------------------------
module id_exe_pipe_reg #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hazard,
    input  logic              perf_clr,

    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              B_in,
    input  logic              S_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       Val_Rn_in,
    input  logic [31:0]       Val_Rm_in,
    input  logic              imm_in,
    input  logic [11:0]       Shift_operand_in,
    input  logic [23:0]       Signed_imm_24_in,
    input  logic [3:0]        Dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [3:0]        SR_in,

    output logic              WB_EN,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              B,
    output logic              S,
    output logic [3:0]        EXE_CMD,
    output logic [31:0]       PC,
    output logic [31:0]       Val_Rn,
    output logic [31:0]       Val_Rm,
    output logic              imm,
    output logic [11:0]       Shift_operand,
    output logic [23:0]       Signed_imm_24,
    output logic [3:0]        Dest,
    output logic [3:0]        src1,
    output logic [3:0]        src2,
    output logic [3:0]        SR,

    output logic              exe_valid,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  issue_cnt
);

    // Slot occupancy: the only state beyond the captured fields themselves.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_VALID = 1'b1
    } slot_t;

    // What happens to the slot at the coming edge (flush > hazard > load).
    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_BUBBLE = 2'd1,
        OP_FLUSH  = 2'd2
    } slot_op_t;

    slot_t    state_q;
    slot_t    state_d;
    slot_op_t slot_op;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Next-state / operation decode
    // ------------------------------------------------------------------
    always_comb begin
        slot_op = OP_LOAD;
        state_d = SLOT_VALID;
        if (flush) begin
            slot_op = OP_FLUSH;
            state_d = SLOT_EMPTY;
        end else if (hazard) begin
            slot_op = OP_BUBBLE;
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign exe_valid = (state_q == SLOT_VALID);

    // ------------------------------------------------------------------
    // Control group: cleared by both bubble and flush so a bubble can
    // never write back or access memory.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            B        <= 1'b0;
            S        <= 1'b0;
            EXE_CMD  <= '0;
        end else if (slot_op == OP_LOAD) begin
            WB_EN    <= WB_EN_in;
            MEM_R_EN <= MEM_R_EN_in;
            MEM_W_EN <= MEM_W_EN_in;
            B        <= B_in;
            S        <= S_in;
            EXE_CMD  <= EXE_CMD_in;
        end else begin
            WB_EN    <= 1'b0;
            MEM_R_EN <= 1'b0;
            MEM_W_EN <= 1'b0;
            B        <= 1'b0;
            S        <= 1'b0;
            EXE_CMD  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Data group: a bubble leaves these untouched (Dest included); every
    // consumer qualifies them with the now-cleared enables. A flush zeroes
    // them so a squashed branch leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC            <= '0;
            Val_Rn        <= '0;
            Val_Rm        <= '0;
            imm           <= 1'b0;
            Shift_operand <= '0;
            Signed_imm_24 <= '0;
            Dest          <= '0;
            src1          <= '0;
            src2          <= '0;
            SR            <= '0;
        end else begin
            case (slot_op)
                OP_LOAD: begin
                    PC            <= PC_in;
                    Val_Rn        <= Val_Rn_in;
                    Val_Rm        <= Val_Rm_in;
                    imm           <= imm_in;
                    Shift_operand <= Shift_operand_in;
                    Signed_imm_24 <= Signed_imm_24_in;
                    Dest          <= Dest_in;
                    src1          <= src1_in;
                    src2          <= src2_in;
                    SR            <= SR_in;
                end
                OP_FLUSH: begin
                    PC            <= '0;
                    Val_Rn        <= '0;
                    Val_Rm        <= '0;
                    imm           <= 1'b0;
                    Shift_operand <= '0;
                    Signed_imm_24 <= '0;
                    Dest          <= '0;
                    src1          <= '0;
                    src2          <= '0;
                    SR            <= '0;
                end
                default: begin
                    // bubble: hold
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters: saturating, perf_clr beats any increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
            issue_cnt  <= '0;
        end else if (perf_clr) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
            issue_cnt  <= '0;
        end else begin
            case (slot_op)
                OP_LOAD:   issue_cnt  <= sat_inc(issue_cnt);
                OP_BUBBLE: bubble_cnt <= sat_inc(bubble_cnt);
                OP_FLUSH:  flush_cnt  <= sat_inc(flush_cnt);
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_id_exe_pipe_reg
//
// Directed test of id_exe_pipe_reg with 4-bit counters: reset, normal issue,
// asynchronous mid-stream reset, load-use bubble, flush over hazard, counter
// saturation and perf_clr priority.
// ----------------------------------------------------------------------------
module tb_id_exe_pipe_reg;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n, flush, hazard, perf_clr;
    logic WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in;
    logic [3:0]  EXE_CMD_in, Dest_in, src1_in, src2_in, SR_in;
    logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
    logic [11:0] Shift_operand_in;
    logic [23:0] Signed_imm_24_in;

    logic WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, exe_valid;
    logic [3:0]  EXE_CMD, Dest, src1, src2, SR;
    logic [31:0] PC, Val_Rn, Val_Rm;
    logic [11:0] Shift_operand;
    logic [23:0] Signed_imm_24;
    logic [CW-1:0] bubble_cnt, flush_cnt, issue_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    id_exe_pipe_reg #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hazard(hazard), .perf_clr(perf_clr),
        .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
        .B_in(B_in), .S_in(S_in), .EXE_CMD_in(EXE_CMD_in), .PC_in(PC_in),
        .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .imm_in(imm_in),
        .Shift_operand_in(Shift_operand_in), .Signed_imm_24_in(Signed_imm_24_in),
        .Dest_in(Dest_in), .src1_in(src1_in), .src2_in(src2_in), .SR_in(SR_in),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
        .EXE_CMD(EXE_CMD), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
        .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
        .Dest(Dest), .src1(src1), .src2(src2), .SR(SR),
        .exe_valid(exe_valid), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
        .issue_cnt(issue_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        flush = 0; hazard = 0; perf_clr = 0;
        WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; B_in = 0; S_in = 0; imm_in = 0;
        EXE_CMD_in = '0; Dest_in = '0; src1_in = '0; src2_in = '0; SR_in = '0;
        PC_in = '0; Val_Rn_in = '0; Val_Rm_in = '0;
        Shift_operand_in = '0; Signed_imm_24_in = '0;
    endtask

    // advance one rising edge and settle just past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        #12;
        check("rst_valid", exe_valid, 0);
        check("rst_wb", WB_EN, 0);
        check("rst_issue", issue_cnt, 0);
        @(negedge clk);
        rst_n = 1;

        // normal issue, 3 cycles
        Val_Rn_in = 32'hA; tick();
        check("iss1_rn", Val_Rn, 32'hA);
        check("iss1_valid", exe_valid, 1);
        Val_Rn_in = 32'hB; tick();
        check("iss2_rn", Val_Rn, 32'hB);
        check("iss2_valid", exe_valid, 1);
        Val_Rn_in = 32'hC; tick();
        check("iss3_rn", Val_Rn, 32'hC);
        check("iss3_valid", exe_valid, 1);
        check("iss3_cnt", issue_cnt, 3);

        // reset mid-stream, asserted between edges
        WB_EN_in = 1; Dest_in = 4'h5; PC_in = 32'h10; tick();
        check("pre_rst_wb", WB_EN, 1);
        check("pre_rst_dest", Dest, 5);
        check("pre_rst_pc", PC, 32'h10);
        check("pre_rst_cnt", issue_cnt, 4);
        #2 rst_n = 0;
        #1;
        check("async_wb", WB_EN, 0);
        check("async_dest", Dest, 0);
        check("async_pc", PC, 0);
        check("async_valid", exe_valid, 0);
        check("async_issue", issue_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        clear_inputs();

        // load-use stall
        MEM_R_EN_in = 1; WB_EN_in = 1; Dest_in = 4'h2; Val_Rm_in = 32'h11; tick();
        check("ld_memr", MEM_R_EN, 1);
        check("ld_dest", Dest, 2);
        check("ld_rm", Val_Rm, 32'h11);
        hazard = 1; Val_Rm_in = 32'hFF; Dest_in = 4'h7; tick();
        check("bub_memr", MEM_R_EN, 0);
        check("bub_wb", WB_EN, 0);
        check("bub_valid", exe_valid, 0);
        check("bub_rm_hold", Val_Rm, 32'h11);
        check("bub_dest_hold", Dest, 2);
        check("bub_cnt", bubble_cnt, 1);
        check("bub_issue", issue_cnt, 1);

        // flush beats hazard
        flush = 1; hazard = 1; EXE_CMD_in = 4'h9; tick();
        check("fl_cmd", EXE_CMD, 0);
        check("fl_rm", Val_Rm, 0);
        check("fl_dest", Dest, 0);
        check("fl_valid", exe_valid, 0);
        check("fl_cnt", flush_cnt, 1);
        check("fl_bub", bubble_cnt, 1);

        // normal issue after flush
        flush = 0; hazard = 0; tick();
        check("post_fl_cmd", EXE_CMD, 9);
        check("post_fl_valid", exe_valid, 1);
        check("post_fl_issue", issue_cnt, 2);

        // bubble counter saturation: 1 + 20 bubbles clamps at 15
        hazard = 1;
        for (int i = 0; i < 13; i++) tick();
        check("sat_mid", bubble_cnt, 14);
        for (int i = 0; i < 7; i++) tick();
        check("sat_hold", bubble_cnt, 15);
        check("sat_issue", issue_cnt, 2);

        // perf_clr beats the hazard increment
        perf_clr = 1; tick();
        check("clr_bub", bubble_cnt, 0);
        check("clr_fl", flush_cnt, 0);
        check("clr_issue", issue_cnt, 0);

        // perf_clr does not disturb the pipeline registers
        hazard = 0; Val_Rn_in = 32'h55; tick();
        check("clr_load_rn", Val_Rn, 32'h55);
        check("clr_load_valid", exe_valid, 1);
        check("clr_load_issue", issue_cnt, 0);

        // issue counter saturation
        perf_clr = 0;
        for (int i = 0; i < 17; i++) tick();
        check("iss_sat", issue_cnt, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_exe_pipe_reg.md
# id_exe_pipe_reg

ID→EXE pipeline register of the ARM forwarding pipeline. Each cycle it captures the decoded instruction and its operands from the ID stage and presents them to the EXE stage. It consumes the hazard stall signal, inserting a bubble, and the EXE-stage branch flush, squashing the instruction. Its registered `Dest`, `WB_EN` and `MEM_R_EN` outputs are the EXE-side inputs that the hazard and forwarding logic compare against. It also keeps saturating bubble, flush and issue counters for pipeline-efficiency measurement.

## Interface
Parameters:
- `CNT_W`, 16, width of each performance counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  branch taken in EXE; squash the incoming instruction.
- `hazard`  in  1  stall from the hazard detection unit; insert a bubble.
- `perf_clr`  in  1  synchronous clear of all three counters.
- `WB_EN_in`, `MEM_R_EN_in`, `MEM_W_EN_in`, `B_in`, `S_in`  in  1 each  ID control bits.
- `EXE_CMD_in`  in  4  ALU command.
- `PC_in`, `Val_Rn_in`, `Val_Rm_in`  in  32 each  PC+4 and register-file read values.
- `imm_in`  in  1  immediate-operand flag.
- `Shift_operand_in`  in  12  shifter operand field.
- `Signed_imm_24_in`  in  24  branch offset.
- `Dest_in`, `src1_in`, `src2_in`  in  4 each  destination and source register numbers.
- `SR_in`  in  4  status flags NZCV.
- Matching outputs without the `_in` suffix: same widths, registered.
- `exe_valid`  out  1  high when the EXE slot holds a real instruction.
- `bubble_cnt`, `flush_cnt`, `issue_cnt`  out  `CNT_W` each  performance counters.

## Operation
- Control group: `WB_EN`, `MEM_R_EN`, `MEM_W_EN`, `B`, `S`, `EXE_CMD`, `exe_valid`.
- Data group: every other output register.
- Slot state per cycle, evaluated with priority rst_n low > flush > hazard > normal. The slot state is effectively 2 states, VALID and EMPTY, encoded by `exe_valid`.
- Reset (`rst_n`=0): every output is 0, counters included. This applies immediately, independent of `clk`. Reset asserted mid-operation discards the in-flight instruction.
- Flush (`flush`=1): control group ← 0, data group ← 0, `exe_valid` ← 0, `flush_cnt` += 1. Flush overrides a simultaneous `hazard`, and that cycle does not increment `bubble_cnt`.
- Bubble (`hazard`=1, `flush`=0): control group ← 0, `exe_valid` ← 0. The data group holds its previous value; downstream ignores it because `WB_EN`, `MEM_R_EN` and `MEM_W_EN` are all 0. `bubble_cnt` += 1.
- Normal: all registers load their `_in` values, `exe_valid` ← 1, `issue_cnt` += 1.
- Counters:
  - Unsigned, saturate at 2^CNT_W−1 with no wrap.
  - `perf_clr` zeroes all three counters and takes priority over any increment in the same cycle. It does not affect the pipeline registers.
- Because `MEM_R_EN` is forced to 0 in a bubble, a load followed by a dependent instruction produces exactly one stall cycle. The second cycle sees `MEM_R_EN`=0 and the hazard unit releases.
- `Dest` holds its old value during a bubble. This is safe because every consumer qualifies `Dest` with `WB_EN` or `MEM_R_EN`.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- No combinational path from any input to any output.
- `hazard` and `flush` must be stable before the rising edge. Both are registered effects only.
- Reset assertion is asynchronous. Deassertion is synchronised externally. The first load occurs at the first rising edge with `rst_n`=1.
- Counter updates occur on the same edge as the pipeline-register update they account for.

## Test plan
- Reset mid-stream: load `WB_EN_in`=1, `Dest_in`=4'h5, `PC_in`=32'h10, then pull `rst_n` low between edges. All outputs read 0 before the next edge, and the counters read 0.
- Normal issue: 3 consecutive cycles with `Val_Rn_in`=32'hA, 32'hB, 32'hC. `Val_Rn` follows one cycle later, `exe_valid`=1 throughout, `issue_cnt`=3.
- Load-use stall: cycle 1 issues `MEM_R_EN_in`=1, `Dest_in`=4'h2. Cycle 2 asserts `hazard`=1 with `Val_Rm_in`=32'hFF. After the edge: `MEM_R_EN`=0, `WB_EN`=0, `exe_valid`=0, `Val_Rm` unchanged, `bubble_cnt`=1.
- Flush beats hazard: `flush`=1 and `hazard`=1 together with `EXE_CMD_in`=4'h9. After the edge all outputs are 0, `flush_cnt`=1, `bubble_cnt` unchanged.
- Saturation with `CNT_W`=4:
  - Hold `hazard` for 20 cycles: `bubble_cnt` stops at 15.
  - Assert `perf_clr` together with `hazard`: `bubble_cnt`=0 after the edge.
